vga_pattern_gen: RTL and testbench



---
 rtl/vga_pattern_gen_if.sv | 25 ++
 rtl/vga_pattern_gen.sv | 149 ++++++++++++++
 tb/tb_vga_pattern_gen.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/vga_pattern_gen_if.sv
// Pixel stream between the timing generator and the test-pattern generator:
// coordinates and control in, packed RGB and valid out.
interface vga_pattern_gen_if #(
  parameter int CW = 10,
  parameter int XW = 10,
  parameter int YW = 10
);
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic            in_valid;
  logic            frame_tick;
  logic [1:0]      mode;
  logic [3*CW-1:0] rgb;
  logic            out_valid;

  modport master (
    output x, y, in_valid, frame_tick, mode,
    input  rgb, out_valid
  );

  modport slave (
    input  x, y, in_valid, frame_tick, mode,
    output rgb, out_valid
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// Two-stage pipelined VGA test-pattern generator: colour bars, checkerboard,
// grey ramp and a bouncing box stepped once per frame_tick.
module vga_pattern_gen #(
  parameter int CW       = 10,
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int NBARS    = 8,
  parameter int CHK_LOG2 = 5,
  parameter int BOX      = 32
) (
  input logic              clk,
  input logic              reset,
  vga_pattern_gen_if.slave pix
);

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_CHECKER = 2'd1,
    PAT_RAMP    = 2'd2,
    PAT_BOX     = 2'd3
  } pattern_e;

  localparam int            BAR_W = H_ACTIVE / NBARS;
  localparam logic [XW-1:0] X_LIM = XW'(H_ACTIVE - BOX);
  localparam logic [YW-1:0] Y_LIM = YW'(V_ACTIVE - BOX);
  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [YW-1:0] Y_ONE = YW'(1);
  localparam logic [CW-1:0] FS    = '1;

  pattern_e        mode_q;
  logic [XW-1:0]   bx_q, bx_d;
  logic [YW-1:0]   by_q, by_d;
  logic            dx_q, dx_d, dy_q, dy_d;

  logic            act_c, chk_c, hit_c;
  logic [2:0]      idx_c;

  logic            v1_q, act1_q, chk1_q, hit1_q;
  logic [2:0]      idx1_q;
  logic [XW-1:0]   x1_q;
  pattern_e        mode1_q;

  logic [3*CW-1:0] colour_d, rgb_q;
  logic [CW-1:0]   ramp_c;
  logic            out_valid_q;

  // Bounce: at a limit the direction flips and the position steps back inward.
  always_comb begin
    bx_d = bx_q;
    by_d = by_q;
    dx_d = dx_q;
    dy_d = dy_q;
    if (pix.frame_tick) begin
      if (dx_q) begin
        if (bx_q == X_LIM) begin dx_d = 1'b0; bx_d = X_LIM - X_ONE; end
        else                     bx_d = bx_q + X_ONE;
      end else begin
        if (bx_q == '0) begin dx_d = 1'b1; bx_d = X_ONE; end
        else                  bx_d = bx_q - X_ONE;
      end
      if (dy_q) begin
        if (by_q == Y_LIM) begin dy_d = 1'b0; by_d = Y_LIM - Y_ONE; end
        else                     by_d = by_q + Y_ONE;
      end else begin
        if (by_q == '0) begin dy_d = 1'b1; by_d = Y_ONE; end
        else                  by_d = by_q - Y_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= PAT_BARS;
      bx_q   <= '0;
      by_q   <= '0;
      dx_q   <= 1'b1;
      dy_q   <= 1'b1;
    end else begin
      if (pix.frame_tick) mode_q <= pattern_e'(pix.mode);
      bx_q <= bx_d;
      by_q <= by_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  // Compares are widened by one bit so bx+BOX / by+BOX cannot wrap.
  always_comb begin
    act_c = pix.in_valid
          && ({1'b0, pix.x} < (XW+1)'(H_ACTIVE))
          && ({1'b0, pix.y} < (YW+1)'(V_ACTIVE));
    idx_c = 3'(pix.x / XW'(BAR_W));
    chk_c = 1'(pix.x >> CHK_LOG2) ^ 1'(pix.y >> CHK_LOG2);
    hit_c = ({1'b0, pix.x} >= {1'b0, bx_q})
         && ({1'b0, pix.x} <  {1'b0, bx_q} + (XW+1)'(BOX))
         && ({1'b0, pix.y} >= {1'b0, by_q})
         && ({1'b0, pix.y} <  {1'b0, by_q} + (YW+1)'(BOX));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q    <= 1'b0;
      act1_q  <= 1'b0;
      chk1_q  <= 1'b0;
      hit1_q  <= 1'b0;
      idx1_q  <= '0;
      x1_q    <= '0;
      mode1_q <= PAT_BARS;
    end else begin
      v1_q    <= pix.in_valid;
      act1_q  <= act_c;
      chk1_q  <= chk_c;
      hit1_q  <= hit_c;
      idx1_q  <= idx_c;
      x1_q    <= pix.x;
      mode1_q <= mode_q;
    end
  end

  always_comb begin
    colour_d = '0;
    ramp_c   = CW'(x1_q) << (CW - XW);
    if (act1_q) begin
      unique case (mode1_q)
        PAT_BARS:    colour_d = {{CW{idx1_q[0]}}, {CW{idx1_q[1]}}, {CW{idx1_q[2]}}};
        PAT_CHECKER: colour_d = {(3*CW){chk1_q}};
        PAT_RAMP:    colour_d = {3{ramp_c}};
        PAT_BOX:     colour_d = hit1_q ? '1 : {{(2*CW){1'b0}}, FS};
        default:     colour_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rgb_q       <= colour_d;
      out_valid_q <= v1_q;
    end
  end

  assign pix.rgb       = rgb_q;
  assign pix.out_valid = out_valid_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: table of pixel vectors plus bounce/reset
// sequences, expectations queued at drive time and checked two edges later.
module tb_vga_pattern_gen;
  localparam int CW = 10;
  localparam int XW = 10;
  localparam int YW = 10;
  localparam logic [CW-1:0]   FS    = '1;
  localparam logic [3*CW-1:0] BLACK = '0;
  localparam logic [3*CW-1:0] WHITE = '1;
  localparam logic [3*CW-1:0] RED   = {FS, {(2*CW){1'b0}}};
  localparam logic [3*CW-1:0] GRN   = {{CW{1'b0}}, FS, {CW{1'b0}}};
  localparam logic [3*CW-1:0] BLU   = {{(2*CW){1'b0}}, FS};
  localparam logic [3*CW-1:0] YEL   = RED | GRN;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_pattern_gen_if #(.CW(CW), .XW(XW), .YW(YW)) pif ();

  vga_pattern_gen #(
    .CW(CW), .XW(XW), .YW(YW), .H_ACTIVE(640), .V_ACTIVE(480),
    .NBARS(8), .CHK_LOG2(5), .BOX(32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .pix  (pif)
  );

  typedef struct {
    bit              ov;
    logic [3*CW-1:0] rgb;
    string           name;
  } exp_t;

  typedef struct {
    int              x;
    int              y;
    bit              v;
    bit              t;
    int              m;
    bit              ov;
    logic [3*CW-1:0] rgb;
    string           name;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [3*CW-1:0] grgb, input logic gov,
                       input logic [3*CW-1:0] ergb, input bit eov);
    checks++;
    if (grgb !== ergb || gov !== eov) begin
      errors++;
      $display("FAIL %s: got rgb=%h out_valid=%b, expected rgb=%h out_valid=%b",
               name, grgb, gov, ergb, eov);
    end
  endtask

  // Drive one pixel, queue its expectation, compare the output due this edge.
  task automatic cycle(input int xi, input int yi, input bit vi, input bit ti, input int mi,
                       input bit eov, input logic [3*CW-1:0] ergb, input string name);
    exp_t e;
    pif.x          = xi[XW-1:0];
    pif.y          = yi[YW-1:0];
    pif.in_valid   = vi;
    pif.frame_tick = ti;
    pif.mode       = mi[1:0];
    sbq.push_back('{eov, ergb, name});
    @(posedge clk);
    #1;
    if (sbq.size() >= 2) begin
      e = sbq.pop_front();
      check(e.name, pif.rgb, pif.out_valid, e.rgb, e.ov);
    end
  endtask

  task automatic add(input int x, input int y, input bit v, input bit t, input int m,
                     input bit ov, input logic [3*CW-1:0] rgb, input string n);
    vecs.push_back('{x, y, v, t, m, ov, rgb, n});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 1'b0, 1'b0, 0, 1'b0, BLACK, "idle");
  endtask

  task automatic ticks(input int n, input int m);
    for (int i = 0; i < n; i++) cycle(0, 0, 1'b0, 1'b1, m, 1'b0, BLACK, "tick");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pif.in_valid   = 1'b0;
    pif.frame_tick = 1'b0;
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // Reset dominates valid pixels and a frame_tick requesting a new mode.
    reset          = 1'b1;
    pif.x          = 10'd560;
    pif.y          = '0;
    pif.in_valid   = 1'b1;
    pif.frame_tick = 1'b1;
    pif.mode       = 2'd1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", pif.rgb, pif.out_valid, BLACK, 1'b0);
    pif.in_valid   = 1'b0;
    pif.frame_tick = 1'b0;
    pif.mode       = 2'd0;
    reset          = 1'b0;

    // Bars come from the reset mode, no tick needed.
    add(0,   0,   0, 0, 0, 0, BLACK, "blank");
    add(0,   0,   1, 0, 0, 1, BLACK, "bars_x0");
    add(79,  0,   1, 0, 0, 1, BLACK, "bars_x79");
    add(80,  0,   1, 0, 0, 1, RED,   "bars_x80");
    add(160, 0,   1, 0, 0, 1, GRN,   "bars_x160");
    add(240, 0,   1, 0, 0, 1, YEL,   "bars_x240");
    add(320, 0,   1, 0, 0, 1, BLU,   "bars_x320");
    add(560, 0,   1, 0, 0, 1, WHITE, "bars_x560");
    add(639, 0,   1, 0, 0, 1, WHITE, "bars_x639");
    add(640, 0,   1, 0, 0, 1, BLACK, "bars_x640");
    add(0,   480, 1, 0, 0, 1, BLACK, "bars_y480");
    add(100, 0,   0, 0, 0, 0, BLACK, "bars_invalid");
    add(0,   0,   0, 1, 1, 0, BLACK, "tick_to_chk");
    add(0,   0,   1, 0, 1, 1, BLACK, "chk_0_0");
    add(32,  0,   1, 0, 1, 1, WHITE, "chk_32_0");
    add(32,  32,  1, 0, 1, 1, BLACK, "chk_32_32");
    add(31,  31,  1, 0, 1, 1, BLACK, "chk_31_31");
    add(64,  32,  1, 0, 1, 1, WHITE, "chk_64_32");
    add(341, 32,  1, 0, 2, 1, WHITE, "mode_no_tick");
    add(0,   0,   0, 1, 2, 0, BLACK, "tick_to_ramp");
    add(341, 0,   1, 0, 2, 1, {3{10'h155}}, "ramp_155");
    add(0,   0,   1, 0, 2, 1, BLACK, "ramp_x0");
    add(639, 479, 1, 0, 2, 1, {3{10'h27F}}, "ramp_639");
    add(700, 0,   1, 0, 2, 1, BLACK, "ramp_x700");
    add(5,   5,   0, 0, 2, 0, BLACK, "ramp_invalid");
    add(341, 0,   1, 1, 1, 1, {3{10'h155}}, "tick_pixel_old");
    add(32,  0,   1, 0, 1, 1, WHITE, "tick_pixel_new");
    add(32,  0,   1, 1, 0, 1, WHITE, "tick_back_old");
    add(80,  0,   1, 0, 0, 1, RED,   "tick_back_new");

    for (int i = 0; i < vecs.size(); i++)
      cycle(vecs[i].x, vecs[i].y, vecs[i].v, vecs[i].t, vecs[i].m,
            vecs[i].ov, vecs[i].rgb, vecs[i].name);
    idle(2);

    // Box bounce from a fresh reset: y hits its limit at tick 448, x at 608.
    do_reset();
    ticks(448, 3);
    cycle(448, 448, 1, 0, 3, 1, WHITE, "box448_corner");
    cycle(479, 479, 1, 0, 3, 1, WHITE, "box448_far");
    cycle(447, 448, 1, 0, 3, 1, BLU,   "box448_left");
    cycle(480, 448, 1, 0, 3, 1, BLU,   "box448_right");
    cycle(448, 447, 1, 0, 3, 1, BLU,   "box448_above");
    ticks(160, 3);
    cycle(608, 288, 1, 0, 3, 1, WHITE, "box608_corner");
    cycle(639, 319, 1, 0, 3, 1, WHITE, "box608_far");
    cycle(607, 288, 1, 0, 3, 1, BLU,   "box608_left");
    cycle(608, 320, 1, 0, 3, 1, BLU,   "box608_below");
    ticks(1, 3);
    cycle(607, 287, 1, 0, 3, 1, WHITE, "box609_corner");
    cycle(639, 287, 1, 0, 3, 1, BLU,   "box609_right");
    cycle(638, 318, 1, 0, 3, 1, WHITE, "box609_far");
    cycle(607, 287, 1, 0, 3, 1, WHITE, "box609_again");

    // Asynchronous reset mid-line while the output is valid.
    check("pre_reset_valid", pif.rgb, pif.out_valid, WHITE, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", pif.rgb, pif.out_valid, BLACK, 1'b0);
    sbq.delete();
    pif.in_valid   = 1'b0;
    pif.frame_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(560, 0, 1, 1, 3, 1, WHITE, "post_reset_bars");
    cycle(1,   1, 1, 0, 3, 1, WHITE, "post_reset_box_in");
    cycle(0,   0, 1, 0, 3, 1, BLU,   "post_reset_box_out");
    cycle(33,  1, 1, 0, 3, 1, BLU,   "post_reset_box_edge");
    cycle(32, 32, 1, 0, 3, 1, WHITE, "post_reset_box_far");
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
